mips_avalon_slave_ram: RTL and testbench

Word-addressed Avalon-MM slave RAM. It is the responder end of the data bus: it serves writes drained by the cache write buffer and reads issued by cache fills.
- Applies a programmable waitrequest stall per transaction.
- Honours byte enables.
- Flags out-of-range and protocol errors.
- Used as main memory in the CPU testbench top and the FPGA top.

---
 rtl/mips_avalon_pkg.sv | 21 ++
 rtl/mips_lfsr8.sv | 21 ++
 rtl/mips_avalon_slave_ram.sv | 121 ++++++++++++
 tb/tb_mips_avalon_slave_ram.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_avalon_pkg.sv
// Shared Avalon-MM definitions for the data-bus slave RAM and the cache write buffer.
package mips_avalon_pkg;

    localparam int          BYTE_LANES      = 4;
    localparam logic [31:0] RESET_BASE_ADDR = 32'hBFC00000;

    typedef struct packed {
        logic [31:0]           address;
        logic                  read;
        logic                  write;
        logic [31:0]           writedata;
        logic [BYTE_LANES-1:0] byteenable;
    } avalon_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCEPT
    } slave_state_t;

endpackage

// File: rtl/mips_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5, advancing on step.
module mips_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] q
);

    logic feedback;

    assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 8'hA5;
        end else if (step) begin
            q <= {q[6:0], feedback};
        end
    end

endmodule

// File: rtl/mips_avalon_slave_ram.sv
// Word-addressed Avalon-MM slave RAM with per-transaction waitrequest stall and sticky error flags.
// Optional macro MIPS_AVALON_RANDOM_STALL_EN replaces the fixed stall with an LFSR-driven 0..3 stall.
//
// state     | meaning
// ST_IDLE   | no request on the bus, cnt held at 0
// ST_WAIT   | request present, cnt < stall_len, waitrequest high
// ST_ACCEPT | request present, cnt == stall_len, transaction commits at this edge
module mips_avalon_slave_ram
    import mips_avalon_pkg::*;
#(
    parameter int          ADDR_BITS    = 10,
    parameter logic [31:0] BASE_ADDR    = RESET_BASE_ADDR,
    parameter int          STALL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [BYTE_LANES-1:0] byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    output logic                  range_err,
    output logic                  protocol_err
);

`ifdef MIPS_AVALON_RANDOM_STALL_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = (STALL_CYCLES < 1) ? 1 : $clog2(STALL_CYCLES + 1);
`endif
    localparam int          DEPTH  = 1 << ADDR_BITS;
    localparam logic [32:0] WINDOW = 33'd4 << ADDR_BITS;

    avalon_req_t          bus;
    logic [31:0]          mem [DEPTH];
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     stall_len;
    logic [31:0]          offset;
    logic [ADDR_BITS-1:0] idx;
    logic                 req;
    logic                 in_range;
    logic                 accept;
    slave_state_t         state;

    assign bus      = {address, read, write, writedata, byteenable};
    assign req      = bus.read | bus.write;
    assign offset   = bus.address - BASE_ADDR;
    assign in_range = {1'b0, offset} < WINDOW;
    assign idx      = offset[ADDR_BITS+1:2];

`ifdef MIPS_AVALON_RANDOM_STALL_EN
    logic [7:0]       lfsr_q;
    logic [CNT_W-1:0] stall_len_q;

    mips_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (accept),
        .q    (lfsr_q)
    );

    // The length is captured when a transaction starts; the first cycle uses the live LFSR value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_len_q <= '0;
        end else if (req && cnt == '0) begin
            stall_len_q <= lfsr_q[1:0];
        end
    end

    assign stall_len = (cnt == '0) ? lfsr_q[1:0] : stall_len_q;
`else
    assign stall_len = CNT_W'(STALL_CYCLES);
`endif

    always_comb begin
        state = ST_IDLE;
        if (req) begin
            state = (cnt == stall_len) ? ST_ACCEPT : ST_WAIT;
        end
    end

    assign accept      = (state == ST_ACCEPT);
    assign waitrequest = (state == ST_WAIT);
    assign readdata    = (accept && bus.read && !bus.write && in_range) ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            range_err    <= 1'b0;
            protocol_err <= 1'b0;
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            case (state)
                ST_WAIT: cnt <= cnt + 1'b1;
                ST_ACCEPT: begin
                    cnt <= '0;
                    if (bus.write && in_range) begin
                        for (int i = 0; i < BYTE_LANES; i++) begin
                            if (bus.byteenable[i]) begin
                                mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
                            end
                        end
                    end
                    if (!in_range) begin
                        range_err <= 1'b1;
                    end
                    if (bus.read && bus.write) begin
                        protocol_err <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_avalon_slave_ram.sv
// Self-checking bench for mips_avalon_slave_ram (default fixed stall of 2 cycles).
module tb_mips_avalon_slave_ram;
    import mips_avalon_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        range_err;
    logic        protocol_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    mips_avalon_slave_ram #(
        .ADDR_BITS    (10),
        .BASE_ADDR    (32'hBFC00000),
        .STALL_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .range_err    (range_err),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request and leaves it asserted; returns the cycles until acceptance.
    task automatic xfer(input string tag, input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_rd,
                        output int cycles);
        address    = a;
        read       = rd;
        write      = wr;
        writedata  = wd;
        byteenable = be;
        if (rd) exp_q.push_back(exp_rd);
        cycles = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            cycles = c;
            if (!waitrequest) break;
            if (rd) chk({tag, "_stall_rd"}, readdata, 32'h0);
        end
        if (waitrequest) chk({tag, "_timeout"}, 32'd1, 32'd0);
        if (rd) chk({tag, "_rd"}, readdata, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        read  = 1'b0;
        write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int cyc;
        xfer(tag, a, 1'b0, 1'b1, d, be, 32'h0, cyc);
        chk({tag, "_cyc"}, cyc, 32'd3);
        bus_idle();
    endtask

    task automatic rd_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int cyc;
        xfer(tag, a, 1'b1, 1'b0, 32'h0, 4'h0, exp, cyc);
        chk({tag, "_cyc"}, cyc, 32'd3);
        bus_idle();
    endtask

    initial begin
        int cyc;
        int total;
        address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wait", waitrequest, 32'd0);
        chk("rst_rdata", readdata, 32'h0);
        chk("rst_rerr", range_err, 32'd0);
        chk("rst_perr", protocol_err, 32'd0);
        @(posedge clk);
        #1;

        wr_word("t1_wr", 32'hBFC00010, 32'hDEADBEEF, 4'hF);
        rd_word("t1_rd", 32'hBFC00010, 32'hDEADBEEF);

        wr_word("t2_wr", 32'hBFC00010, 32'h11223344, 4'b0101);
        rd_word("t2_rd", 32'hBFC00010, 32'hDE22BE44);

        wr_word("t3_base", 32'hBFC00000, 32'h55AA55AA, 4'hF);
        wr_word("t3_top", 32'hBFC00FFC, 32'hA1B2C3D4, 4'hF);
        chk("t3_rerr_in", range_err, 32'd0);
        wr_word("t3_zero", 32'h00000000, 32'h12345678, 4'hF);
        chk("t3_rerr_set", range_err, 32'd1);
        wr_word("t3_past", 32'hBFC01000, 32'h99999999, 4'hF);
        rd_word("t3_rd_zero", 32'h00000000, 32'h0);
        rd_word("t3_rd_base", 32'hBFC00000, 32'h55AA55AA);
        rd_word("t3_rd_top", 32'hBFC00FFC, 32'hA1B2C3D4);
        chk("t3_rerr_sticky", range_err, 32'd1);

        total = 0;
        for (int i = 0; i < 4; i++) begin
            xfer("t4_wr", 32'hBFC00100 + 32'(4 * i), 1'b0, 1'b1, 32'h0A0B0C00 + 32'(i), 4'hF, 32'h0, cyc);
            total += cyc;
        end
        bus_idle();
        chk("t4_total", total, 32'd12);
        for (int i = 0; i < 4; i++) begin
            rd_word("t4_rd", 32'hBFC00100 + 32'(4 * i), 32'h0A0B0C00 + 32'(i));
        end

        chk("t6_perr_pre", protocol_err, 32'd0);
        xfer("t6_rw", 32'hBFC00200, 1'b1, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, cyc);
        chk("t6_rw_cyc", cyc, 32'd3);
        bus_idle();
        chk("t6_perr", protocol_err, 32'd1);
        rd_word("t6_rd", 32'hBFC00200, 32'hCAFEF00D);
        wr_word("t6_be0", 32'hBFC00200, 32'h00000000, 4'h0);
        rd_word("t6_rd_be0", 32'hBFC00200, 32'hCAFEF00D);

        // Reset during the second stall cycle of a held write.
        address = 32'hBFC00040; read = 1'b0; write = 1'b1; writedata = 32'h5A5A1234; byteenable = 4'hF;
        @(negedge clk);
        chk("t5_wait1", waitrequest, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_wait2", waitrequest, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t5_rerr_clr", range_err, 32'd0);
        chk("t5_perr_clr", protocol_err, 32'd0);
        xfer("t5_restart", 32'hBFC00040, 1'b0, 1'b1, 32'h5A5A1234, 4'hF, 32'h0, cyc);
        chk("t5_restart_cyc", cyc, 32'd3);
        bus_idle();
        rd_word("t5_rd", 32'hBFC00040, 32'h5A5A1234);
        rd_word("t5_mem_clr", 32'hBFC00010, 32'h0);

        // Reset coinciding with the accept edge of a read+write.
        address = 32'hBFC00300; read = 1'b1; write = 1'b1; writedata = 32'h87654321; byteenable = 4'hF;
        @(negedge clk);
        chk("t7_wait1", waitrequest, 32'd1);
        @(negedge clk);
        chk("t7_wait2", waitrequest, 32'd1);
        @(negedge clk);
        chk("t7_accept", waitrequest, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; read = 1'b0; write = 1'b0;
        chk("t7_perr", protocol_err, 32'd0);
        @(posedge clk);
        #1;
        rd_word("t7_rd", 32'hBFC00300, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
